arb_stream_mux: RTL and testbench
=================================

ARB_STREAM_MUX -- requirements
Module: arb_stream_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each channel data word.
REQ-002 Parameter NUM_INPUTS, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter SEL_WIDTH, default 2: select/grant index width, SHALL equal ceil(log2(NUM_INPUTS)).
REQ-004 Parameter MAX_BURST, default 4: maximum consecutive transfers from one channel when ARB_STREAM_MUX_HOLD_EN is defined, legal range 1..255.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  NUM_INPUTS*DATA_WIDTH  concatenated channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_valid  input  NUM_INPUTS  per-channel valid.
REQ-009 in_ready  output  NUM_INPUTS  per-channel ready.
REQ-010 mode  input  1  0 = fixed select by s, 1 = round-robin arbitration.
REQ-011 s  input  SEL_WIDTH  channel select used when mode = 0.
REQ-012 y  output  DATA_WIDTH  registered output data.
REQ-013 y_valid  output  1  output register holds a word.
REQ-014 y_ready  input  1  downstream accepts y this cycle.
REQ-015 y_grant  output  SEL_WIDTH  index of channel that supplied the current y.

Function
REQ-016 Transfer out occurs on a clock edge with y_valid && y_ready; transfer in from channel g occurs on a clock edge with in_valid[g] && in_ready[g].
REQ-017 Output register SHALL be able to load when !y_valid || y_ready (load_en); full throughput of one word per cycle with y_ready held high.
REQ-018 in_ready[i] SHALL be 1 only for i = current grant g and only when load_en; all other bits 0; in_ready SHALL NOT depend combinationally on in_valid of other channels in mode 0.
REQ-019 Mode 0: g = s; s values >= NUM_INPUTS SHALL grant no channel (in_ready all 0, no load).
REQ-020 Mode 1: g = first channel with in_valid set, searching upward from pointer ptr with wrap-around from NUM_INPUTS-1 to 0; no request -> no grant.
REQ-021 On a transfer in from g, y <= channel g data, y_grant <= g, y_valid <= 1; latency input-to-output exactly 1 cycle.
REQ-022 On transfer out without simultaneous transfer in, y_valid <= 0; y and y_grant hold their value.
REQ-023 Simultaneous transfer out and in SHALL replace the word with no bubble.
REQ-024 Mode 1: after each transfer in from g, ptr <= (g+1) mod NUM_INPUTS; ptr unchanged in mode 0 and when no transfer in.
REQ-025 Changing mode or s while y_valid = 1 SHALL not alter y, y_valid or y_grant; it affects only the next load.
REQ-026 Arbiter state: IDLE (y_valid = 0) and FULL (y_valid = 1); IDLE->FULL on transfer in; FULL->IDLE on transfer out without transfer in; otherwise stay.

Reset
REQ-027 While rst_n = 0: y = 0, y_valid = 0, y_grant = 0, ptr = 0, burst counter = 0, in_ready = 0, asynchronously.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; first grant after release in mode 1 starts search at channel 0.

Configuration
REQ-029 Macro ARB_STREAM_MUX_HOLD_EN: when defined, mode 1 keeps grant on channel g while in_valid[g] stays 1, up to MAX_BURST consecutive transfers, then advances ptr to (g+1) mod NUM_INPUTS; a burst counter resets to 0 on grant change, on in_valid[g] = 0, and on reset.
REQ-030 Without ARB_STREAM_MUX_HOLD_EN: behaviour exactly per REQ-024, no burst counter logic present.

Verification
REQ-031 Mode 0, s = 2, in_valid = 4'b1111, channel data 0x10,0x11,0x12,0x13, y_ready = 1 -> y = 0x12, y_grant = 2 every cycle after first, in_ready = 4'b0100.
REQ-032 Mode 1, all valid, y_ready = 1, no HOLD_EN -> y_grant sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-033 Mode 1, in_valid = 4'b1010, y_ready = 1 -> y_grant alternates 1,3,1,3; channels 0 and 2 never get in_ready.
REQ-034 y_valid = 1, y_ready = 0 for 3 cycles with all valid -> y, y_grant stable, in_ready = 0; release y_ready -> next grant loads same cycle as transfer out.
REQ-035 HOLD_EN, MAX_BURST = 2, all valid, y_ready = 1 -> y_grant sequence 0,0,1,1,2,2,3,3; drop in_valid[1] after one transfer -> grant moves to 2 next.
REQ-036 Assert rst_n = 0 with y_valid = 1 mid-stream -> y_valid = 0, y = 0 immediately; after release mode 1 first y_grant = 0 with all valid.

Source files
------------

// File: rtl/arb_stream_mux.sv
// Registered N:1 stream multiplexer with fixed-select or round-robin arbitration.
// Optional burst hold in round-robin mode is enabled by defining ARB_STREAM_MUX_HOLD_EN.
module arb_stream_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    input  logic                             mode,
    input  logic [SEL_WIDTH-1:0]             s,
    output logic [DATA_WIDTH-1:0]            y,
    output logic                             y_valid,
    input  logic                             y_ready,
    output logic [SEL_WIDTH-1:0]             y_grant
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]            state_reg, state_next;
    logic [DATA_WIDTH-1:0] y_reg;
    logic [SEL_WIDTH-1:0]  grant_reg;
    logic [SEL_WIDTH-1:0]  ptr_reg, ptr_next;

    logic [DATA_WIDTH-1:0] ch_data [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] grant_hot;
    logic                  load_en, load, grant_valid, s_in_range;
    logic [SEL_WIDTH-1:0]  grant, grant_wrap_inc;
    logic                  rr_found;
    logic [SEL_WIDTH-1:0]  rr_idx, rr_off;
    logic [SEL_WIDTH:0]    rr_sum;
    logic [2*NUM_INPUTS-1:0] rr_dbl;

    generate
        if (NUM_INPUTS < 2 || NUM_INPUTS > 16)
            $error("arb_stream_mux: NUM_INPUTS out of range");
        if (SEL_WIDTH != $clog2(NUM_INPUTS))
            $error("arb_stream_mux: SEL_WIDTH must be clog2(NUM_INPUTS)");
        if (MAX_BURST < 1 || MAX_BURST > 255)
            $error("arb_stream_mux: MAX_BURST out of range");

        if (NUM_INPUTS == (1 << SEL_WIDTH)) begin : g_full_range
            assign s_in_range = 1'b1;
        end else begin : g_part_range
            assign s_in_range = (int'(s) < NUM_INPUTS);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
            assign ch_data[gi]   = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign grant_hot[gi] = grant_valid && (grant == SEL_WIDTH'(gi));
            // in_ready is forced low while reset is asserted, independent of the clock
            assign in_ready[gi]  = rst_n && load_en && grant_hot[gi];
        end
    endgenerate

    // Round-robin search: rotate valids so ptr sits at bit 0, take the lowest set bit.
    assign rr_dbl = {in_valid, in_valid} >> ptr_reg;

    always_comb begin
        rr_found = 1'b0;
        rr_off   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (rr_dbl[k]) begin
                rr_found = 1'b1;
                rr_off   = SEL_WIDTH'(k);
            end
        end
        rr_sum = {1'b0, ptr_reg} + {1'b0, rr_off};
        if (int'(rr_sum) >= NUM_INPUTS)
            rr_idx = SEL_WIDTH'(int'(rr_sum) - NUM_INPUTS);
        else
            rr_idx = rr_sum[SEL_WIDTH-1:0];
    end

    assign grant_valid    = mode ? rr_found : s_in_range;
    assign grant          = mode ? rr_idx : s;
    assign grant_wrap_inc = (int'(grant) == NUM_INPUTS - 1) ? '0 : grant + SEL_WIDTH'(1);
    assign load_en        = (state_reg == ST_IDLE) || y_ready;
    assign load           = load_en && |(in_valid & grant_hot);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (load) state_next = ST_FULL;
            ST_FULL: if (y_ready && !load) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef ARB_STREAM_MUX_HOLD_EN
    logic [7:0]            burst_reg, burst_next;
    logic [8:0]            burst_inc;
    logic [NUM_INPUTS-1:0] last_hot;

    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_last
            assign last_hot[gi] = (grant_reg == SEL_WIDTH'(gi));
        end
    endgenerate

    // During a burst ptr parks on the granted channel so the search re-selects it.
    always_comb begin
        ptr_next   = ptr_reg;
        burst_next = burst_reg;
        burst_inc  = 9'd1;
        if (load && mode) begin
            if (grant == grant_reg && burst_reg != 8'd0)
                burst_inc = {1'b0, burst_reg} + 9'd1;
            if (int'(burst_inc) >= MAX_BURST) begin
                ptr_next   = grant_wrap_inc;
                burst_next = 8'd0;
            end else begin
                ptr_next   = grant;
                burst_next = burst_inc[7:0];
            end
        end else if (load) begin
            burst_next = 8'd0;
        end else if (!(|(in_valid & last_hot))) begin
            burst_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            burst_reg <= 8'd0;
        else
            burst_reg <= burst_next;
    end
`else
    assign ptr_next = (load && mode) ? grant_wrap_inc : ptr_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            y_reg     <= '0;
            grant_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (load) begin
                y_reg     <= ch_data[grant];
                grant_reg <= grant;
            end
        end
    end

    assign y       = y_reg;
    assign y_valid = (state_reg == ST_FULL);
    assign y_grant = grant_reg;

endmodule

// File: tb/tb_arb_stream_mux.sv
// Directed-vector bench for arb_stream_mux; expectations follow ARB_STREAM_MUX_HOLD_EN when defined.
module tb_arb_stream_mux;

    localparam int DW = 8;
    localparam int NI = 4;
    localparam int SW = 2;
`ifdef ARB_STREAM_MUX_HOLD_EN
    localparam int MB = 2;
`else
    localparam int MB = 4;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI*DW-1:0]  in_data;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_ready;
    logic              mode;
    logic [SW-1:0]     s;
    logic [DW-1:0]     y;
    logic              y_valid;
    logic              y_ready;
    logic [SW-1:0]     y_grant;

    int vec_cnt = 0;
    int err_cnt = 0;
    int rr_seq[$];
    int alt_seq[$];
    int last_g;

    always #5 clk = ~clk;

    arb_stream_mux #(
        .DATA_WIDTH(DW),
        .NUM_INPUTS(NI),
        .SEL_WIDTH (SW),
        .MAX_BURST (MB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode    (mode),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_grant (y_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("  ok %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
`ifdef ARB_STREAM_MUX_HOLD_EN
        rr_seq  = '{0, 0, 1, 1, 2, 2, 3, 3};
        alt_seq = '{1, 1, 3, 3, 1, 1};
`else
        rr_seq  = '{0, 1, 2, 3, 0};
        alt_seq = '{1, 3, 1, 3};
`endif
        rst_n    = 1'b0;
        mode     = 1'b0;
        s        = 2'd2;
        in_valid = 4'hF;
        y_ready  = 1'b1;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        last_g   = 0;

        repeat (2) @(negedge clk);
        check("rst_y",        32'(y),        0);
        check("rst_y_valid",  32'(y_valid),  0);
        check("rst_y_grant",  32'(y_grant),  0);
        check("rst_in_ready", 32'(in_ready), 0);

        // fixed select s=2
        rst_n = 1'b1;
        #1;
        check("m0_idle_ready", 32'(in_ready), 'h4);
        check("m0_idle_valid", 32'(y_valid),  0);
        repeat (3) begin
            tick;
            check("m0_y",     32'(y),        'h12);
            check("m0_grant", 32'(y_grant),  2);
            check("m0_valid", 32'(y_valid),  1);
            check("m0_ready", 32'(in_ready), 'h4);
        end

        // backpressure: select and data changes must not disturb the held word
        y_ready = 1'b0;
        s       = 2'd1;
        in_data[23:16] = 8'h55;
        #1;
        check("stall_ready_now", 32'(in_ready), 0);
        repeat (3) begin
            tick;
            check("stall_y",     32'(y),        'h12);
            check("stall_grant", 32'(y_grant),  2);
            check("stall_valid", 32'(y_valid),  1);
            check("stall_ready", 32'(in_ready), 0);
        end

        // round robin, all valid; first load coincides with the pending transfer out
        y_ready = 1'b1;
        mode    = 1'b1;
        s       = 2'd2;
        in_data[23:16] = 8'h12;
        foreach (rr_seq[i]) begin
            tick;
            check("rr_grant", 32'(y_grant), 32'(rr_seq[i]));
            check("rr_y",     32'(y),       32'('h10 + rr_seq[i]));
            check("rr_valid", 32'(y_valid), 1);
        end

        // round robin with only channels 1 and 3 requesting
        in_valid = 4'b1010;
        foreach (alt_seq[i]) begin
            tick;
            check("alt_grant",    32'(y_grant),          32'(alt_seq[i]));
            check("alt_valid",    32'(y_valid),          1);
            check("alt_no_0_2",   32'(in_ready & 4'h5),  0);
            last_g = alt_seq[i];
        end

        // fixed select on an idle channel: ready still asserted, word drains, y holds
        mode     = 1'b0;
        s        = 2'd0;
        in_valid = 4'b1110;
        #1;
        check("m0_novalid_ready", 32'(in_ready), 'h1);
        tick;
        check("drain_valid", 32'(y_valid),  0);
        check("drain_grant", 32'(y_grant),  32'(last_g));
        check("drain_y",     32'(y),        32'('h10 + last_g));
        check("drain_ready", 32'(in_ready), 'h1);

        // reset mid-stream
        in_valid = 4'hF;
        s        = 2'd3;
        tick;
        check("pre_rst_y",     32'(y),       'h13);
        check("pre_rst_valid", 32'(y_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(y_valid),  0);
        check("async_rst_y",     32'(y),        0);
        check("async_rst_grant", 32'(y_grant),  0);
        check("async_rst_ready", 32'(in_ready), 0);

        @(negedge clk);
        rst_n = 1'b1;
        mode  = 1'b1;
        tick;
        check("post_rst_grant", 32'(y_grant), 0);
        check("post_rst_y",     32'(y),       'h10);
`ifdef ARB_STREAM_MUX_HOLD_EN
        tick;
        check("hold_grant0", 32'(y_grant), 0);
`endif
        tick;
        check("pre_drop_grant", 32'(y_grant), 1);
        in_valid = 4'b1101;
        tick;
        check("drop_grant", 32'(y_grant), 2);
        check("drop_y",     32'(y),       'h12);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
